// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and types for the eight-digit multiplexed clock display.
// Segment patterns are active-low in gfedcba order.
package seven_seg_scanner_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam logic [6:0]  BCD_MAX    = 7'd99;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [2:0] POS_HOURS_TENS   = 3'd7;
    localparam logic [2:0] POS_HOURS_ONES   = 3'd6;
    localparam logic [2:0] POS_MINUTES_TENS = 3'd5;
    localparam logic [2:0] POS_MINUTES_ONES = 3'd4;
    localparam logic [2:0] POS_SECONDS_TENS = 3'd3;
    localparam logic [2:0] POS_SECONDS_ONES = 3'd2;
    localparam logic [2:0] POS_CENTIS_TENS  = 3'd1;
    localparam logic [2:0] POS_CENTIS_ONES  = 3'd0;

    typedef struct packed {
        logic [4:0] hours;
        logic [5:0] minutes;
        logic [5:0] seconds;
        logic [6:0] centis;
    } snapshot_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_scanner_two_digit_bcd.sv
// Combinational binary-to-two-digit-BCD converter; values above 99 saturate
// so an out-of-range field still shows a sane 99 instead of garbage.
module two_digit_bcd
    import seven_seg_scanner_pkg::*;
(
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0] clamped;

    always_comb begin
        clamped = (bin > BCD_MAX) ? BCD_MAX : bin;
        tens    = 4'(clamped / 7'd10);
        ones    = 4'(clamped % 7'd10);
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for an 8-digit HH.MM.SS.cc display with a tear-free
// frame snapshot and an alarm blink that blanks every digit on alternate phases.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 4,
    parameter int unsigned BLINK_DIV = 25
) (
    input  logic                  clockSignal,
    input  logic                  startOrStop,
    input  logic [4:0]            hoursIn,
    input  logic [5:0]            minutesIn,
    input  logic [5:0]            secondsIn,
    input  logic [6:0]            centisIn,
    input  logic                  ringIn,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            segments,
    output logic                  dp,
    output logic                  frameDone
);

    localparam logic [15:0] DIV_LAST   = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_DIV - 1);

    logic [15:0]           div_q, div_d;
    logic [2:0]            idx_q, idx_d;
    snapshot_t             snap_q, snap_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;
    logic                  phase_q, phase_d;
    logic                  frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic       load;
    logic       div_wrap;
    logic [2:0] pos;
    logic [6:0] field_bin [4];
    logic [3:0] tens      [4];
    logic [3:0] ones      [4];
    logic [3:0] digit_val;
    logic       digit_blank;

    always_comb begin
        div_wrap     = (div_q == DIV_LAST);
        load         = (div_q == '0) && (idx_q == '0);
        div_d        = div_wrap ? '0 : div_q + 16'd1;
        idx_d        = div_wrap ? idx_q + 3'd1 : idx_q;
        snap_d       = load ? '{hours: hoursIn, minutes: minutesIn,
                                seconds: secondsIn, centis: centisIn}
                            : snap_q;
        frame_done_d = load;

        // Blink phase advances on frame boundaries only while the alarm rings.
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (!ringIn) begin
            frame_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (load) begin
            if (frame_cnt_q == BLINK_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // Decode from the next snapshot so the digit shown on the load cycle
    // already belongs to the new frame.
    assign field_bin[0] = {2'b00, snap_d.hours};
    assign field_bin[1] = {1'b0, snap_d.minutes};
    assign field_bin[2] = {1'b0, snap_d.seconds};
    assign field_bin[3] = snap_d.centis;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
            two_digit_bcd u_bcd (
                .bin  (field_bin[gi]),
                .tens (tens[gi]),
                .ones (ones[gi])
            );
        end
    endgenerate

    always_comb begin
        pos         = ~idx_q;
        digit_val   = '0;
        digit_blank = 1'b0;
        case (pos)
            POS_HOURS_TENS: begin
                digit_val   = tens[0];
                digit_blank = (tens[0] == 4'd0);
            end
            POS_HOURS_ONES:   digit_val = ones[0];
            POS_MINUTES_TENS: digit_val = tens[1];
            POS_MINUTES_ONES: digit_val = ones[1];
            POS_SECONDS_TENS: digit_val = tens[2];
            POS_SECONDS_ONES: digit_val = ones[2];
            POS_CENTIS_TENS:  digit_val = tens[3];
            POS_CENTIS_ONES:  digit_val = ones[3];
            default:          digit_val = '0;
        endcase
        seg_d   = digit_blank ? SEG_BLANK : seg_encode(digit_val);
        anode_d = phase_d ? '1 : ~(NUM_DIGITS'(1) << pos);
        dp_d    = !((pos == POS_HOURS_ONES) || (pos == POS_MINUTES_ONES) ||
                    (pos == POS_SECONDS_ONES));
    end

    always_ff @(posedge clockSignal or posedge startOrStop) begin
        if (startOrStop) begin
            div_q        <= '0;
            idx_q        <= '0;
            snap_q       <= '0;
            frame_cnt_q  <= '0;
            phase_q      <= 1'b0;
            frame_done_q <= 1'b0;
            anode_q      <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            frame_cnt_q  <= frame_cnt_d;
            phase_q      <= phase_d;
            frame_done_q <= frame_done_d;
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign anode     = anode_q;
    assign segments  = seg_q;
    assign dp        = dp_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: directed scenarios plus random
// traffic compared against a cycle-count based behavioural model.
module tb_seven_seg_scanner;

    localparam int SD = 2;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] hours = '0;
    logic [5:0] minutes = '0;
    logic [5:0] seconds = '0;
    logic [6:0] centis = '0;
    logic       ring = 1'b0;
    logic [7:0] anode;
    logic [6:0] segments;
    logic       dp;
    logic       frame_done;

    int checks = 0;
    int failures = 0;

    seven_seg_scanner #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clockSignal (clk),
        .startOrStop (rst),
        .hoursIn     (hours),
        .minutesIn   (minutes),
        .secondsIn   (seconds),
        .centisIn    (centis),
        .ringIn      (ring),
        .anode       (anode),
        .segments    (segments),
        .dp          (dp),
        .frameDone   (frame_done)
    );

    always #5 clk = ~clk;

    // Behavioural model: position derived from edges since reset release.
    int         m_t, m_n, m_pos;
    int         s_h, s_m, s_s, s_c;
    bit         m_load, m_dark;
    logic [7:0] exp_anode = 8'hFF;
    logic [6:0] exp_seg = 7'h7F;
    logic       exp_dp = 1'b1;
    logic       exp_fd = 1'b0;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;
            3: return 7'h30;  4: return 7'h19;  5: return 7'h12;
            6: return 7'h02;  7: return 7'h78;  8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] expect_seg(input int pos, input int h, input int m,
                                              input int s, input int c);
        int v;
        int d;
        case (pos / 2)
            3: v = h;
            2: v = m;
            1: v = s;
            default: v = c;
        endcase
        if (v > 99) v = 99;
        d = (pos % 2 == 1) ? v / 10 : v % 10;
        if (pos == 7 && d == 0) return 7'h7F;
        return seg_of(d);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_n = 0;
            exp_anode = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
        end else begin
            m_load = (m_t % (8 * SD)) == 0;
            if (m_load) begin
                s_h = hours; s_m = minutes; s_s = seconds; s_c = centis;
            end
            if (!ring) m_n = 0;
            else if (m_load) m_n++;
            m_dark    = ring && ((m_n / BD) % 2 == 1);
            m_pos     = 7 - (m_t / SD) % 8;
            exp_anode = m_dark ? 8'hFF : ~(8'h01 << m_pos);
            exp_seg   = expect_seg(m_pos, s_h, s_m, s_s, s_c);
            exp_dp    = (m_pos == 6 || m_pos == 4 || m_pos == 2) ? 1'b0 : 1'b1;
            exp_fd    = m_load;
            m_t++;
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic sync_frame(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic set_time(input int h, input int m, input int s, input int c);
        hours = 5'(h); minutes = 6'(m); seconds = 6'(s); centis = 7'(c);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_time(12, 34, 56, 78);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if ({anode, segments, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got anode=%h seg=%h dp=%b fd=%b want FF 7F 1 0",
                         i, anode, segments, dp, frame_done);
            end
        end
    endtask

    task automatic test_normal_scan;
        logic [6:0] tbl [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00};
        bit ok;
        rst = 1'b0;
        for (int i = 0; i < 48; i++) begin
            tick();
            checks++;
            if ({anode, segments, dp, frame_done} !== {exp_anode, exp_seg, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL scan_model cyc=%0d got %h %h %b %b want %h %h %b %b", i,
                         anode, segments, dp, frame_done, exp_anode, exp_seg, exp_dp, exp_fd);
            end
        end
        sync_frame(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL scan_sync got no frameDone want frameDone within 40 cycles");
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (anode !== ~(8'h80 >> (k / 2)) || segments !== tbl[k / 2] ||
                dp !== ((k / 2 == 1 || k / 2 == 3 || k / 2 == 5) ? 1'b0 : 1'b1) ||
                frame_done !== (k == 0)) begin
                failures++;
                $display("FAIL scan_table k=%0d got anode=%h seg=%h dp=%b fd=%b want anode=%h seg=%h",
                         k, anode, segments, dp, frame_done, ~(8'h80 >> (k / 2)), tbl[k / 2]);
            end
            tick();
        end
        checks++;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL scan_period got fd=%b want 1 after 16 cycles", frame_done);
        end
    endtask

    task automatic test_leading_zero_clamp;
        bit ok;
        set_time(5, $urandom_range(0, 63), $urandom_range(0, 63), 120);
        sync_frame(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL lz_sync got no frameDone want frameDone within 40 cycles");
        end
        for (int k = 0; k < 16; k++) begin
            if (k == 0 || k == 2 || k == 12 || k == 14) begin
                logic [6:0] want;
                want = (k == 0) ? 7'h7F : (k == 2) ? 7'h12 : 7'h10;
                checks++;
                if (segments !== want) begin
                    failures++;
                    $display("FAIL lz_clamp k=%0d got seg=%h want %h", k, segments, want);
                end
            end
            tick();
        end
    endtask

    task automatic test_no_tearing;
        bit ok;
        set_time(12, 34, 56, 78);
        sync_frame(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL tear_sync got no frameDone want frameDone within 40 cycles");
        end
        for (int k = 0; k < 16; k++) begin
            if (k == 6) minutes = 6'd59;
            if (k >= 4 && k < 8) begin
                checks++;
                if (segments !== ((k < 6) ? 7'h30 : 7'h19)) begin
                    failures++;
                    $display("FAIL tear_old k=%0d got seg=%h want %h", k, segments,
                             (k < 6) ? 7'h30 : 7'h19);
                end
            end
            tick();
        end
        checks++;
        if (frame_done !== 1'b1) begin
            failures++;
            $display("FAIL tear_frame got fd=%b want 1", frame_done);
        end
        for (int k = 0; k < 8; k++) begin
            if (k >= 4) begin
                checks++;
                if (segments !== ((k < 6) ? 7'h12 : 7'h10)) begin
                    failures++;
                    $display("FAIL tear_new k=%0d got seg=%h want %h", k, segments,
                             (k < 6) ? 7'h12 : 7'h10);
                end
            end
            tick();
        end
    endtask

    task automatic test_blink;
        int  n = 0;
        bit  seen = 1'b0;
        ring = 1'b1;
        for (int i = 0; i < 16 * 10; i++) begin
            tick();
            checks++;
            if ({anode, segments, dp, frame_done} !== {exp_anode, exp_seg, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL blink_model cyc=%0d got %h %h %b %b want %h %h %b %b", i,
                         anode, segments, dp, frame_done, exp_anode, exp_seg, exp_dp, exp_fd);
            end
            if (frame_done === 1'b1) begin
                n++;
                checks++;
                if ((anode === 8'hFF) !== ((n / BD) % 2 == 1)) begin
                    failures++;
                    $display("FAIL blink_phase frame=%0d got anode=%h want dark=%0d", n, anode,
                             (n / BD) % 2);
                end
            end
        end
        for (int i = 0; i < 80; i++) begin
            if (anode === 8'hFF) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL blink_dark got no dark cycle want anode=FF within 80 cycles");
        end
        ring = 1'b0;
        tick();
        checks++;
        if (anode === 8'hFF || anode !== exp_anode) begin
            failures++;
            $display("FAIL blink_drop got anode=%h want %h", anode, exp_anode);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: hours   = 5'($urandom_range(0, 31));
                    1: minutes = 6'($urandom_range(0, 63));
                    2: seconds = 6'($urandom_range(0, 63));
                    default: centis = 7'($urandom_range(0, 127));
                endcase
            end
            if ($urandom_range(0, 49) == 0) ring = ~ring;
            tick();
            checks++;
            if ({anode, segments, dp, frame_done} !== {exp_anode, exp_seg, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL random_model cyc=%0d got %h %h %b %b want %h %h %b %b", i,
                         anode, segments, dp, frame_done, exp_anode, exp_seg, exp_dp, exp_fd);
            end
        end
        ring = 1'b0;
    endtask

    task automatic test_mid_reset;
        bit ok;
        set_time(12, 34, 56, 78);
        sync_frame(ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL mrst_sync got no frameDone want frameDone within 40 cycles");
        end
        repeat (10) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({anode, segments, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL mrst_async got %h %h %b %b want FF 7F 1 0",
                     anode, segments, dp, frame_done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({anode, segments, dp, frame_done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL mrst_hold cyc=%0d got %h %h %b %b want FF 7F 1 0", i,
                         anode, segments, dp, frame_done);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if (frame_done !== 1'b1 || anode !== 8'h7F || segments !== 7'h79) begin
            failures++;
            $display("FAIL mrst_restart got fd=%b anode=%h seg=%h want 1 7F 79",
                     frame_done, anode, segments);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({anode, segments, dp, frame_done} !== {exp_anode, exp_seg, exp_dp, exp_fd}) begin
                failures++;
                $display("FAIL mrst_model cyc=%0d got %h %h %b %b want %h %h %b %b", i,
                         anode, segments, dp, frame_done, exp_anode, exp_seg, exp_dp, exp_fd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_scan();
        test_leading_zero_clamp();
        test_no_tearing();
        test_blink();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
